// File: rtl/hex_record_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_record_tx : snapshots channel/aux words and streams them as one      |
// |                 ASCII hex record (optional XOR checksum) to uart_tx.     |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module hex_record_tx #(
  parameter int          NUM_CH    = 5,
  parameter int          CH_WIDTH  = 30,
  parameter int          AUX_WIDTH = 28,
  parameter logic [7:0]  SEP       = 8'h2C,
  parameter int          CKSUM_EN  = 0,
  parameter int          OVR_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH*CH_WIDTH-1:0]   i_ch_data,
  input  logic [AUX_WIDTH-1:0]         i_aux_data,
  input  logic                         i_tx_start,
  input  logic                         i_tx_empty,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_en,
  output logic                         o_busy,
  output logic [OVR_WIDTH-1:0]         o_overrun_cnt
);

  localparam int DCH      = (CH_WIDTH + 3) / 4;
  localparam int DAUX     = (AUX_WIDTH + 3) / 4;
  localparam int NTRL     = (CKSUM_EN != 0) ? 5 : 2;
  localparam int LEN      = NUM_CH * (DCH + 1) + DAUX + NTRL;
  localparam int IDX_W    = $clog2(LEN);
  localparam int FLD_W    = $clog2(NUM_CH + 2);
  localparam int DIG_W    = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_RDY = 2'd1;
  localparam logic [1:0] S_STROBE   = 2'd2;
  localparam logic [1:0] S_WAIT_ACK = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [FLD_W-1:0]            fld_q, fld_d;
  logic [DIG_W-1:0]            dig_q, dig_d;
  logic [NUM_CH*CH_WIDTH-1:0]  ch_q, ch_d;
  logic [AUX_WIDTH-1:0]        aux_q, aux_d;
  logic [7:0]                  cks_q, cks_d;
  logic [7:0]                  data_q, data_d;
  logic [OVR_WIDTH-1:0]        ovr_q, ovr_d;

  logic [CH_WIDTH-1:0]         ch_sel;
  logic [DCH*4-1:0]            ch_pad;
  logic [DAUX*4-1:0]           aux_pad;
  logic [3:0]                  ch_nib, aux_nib;
  logic [7:0]                  cur_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      fld_q   <= '0;
      dig_q   <= '0;
      ch_q    <= '0;
      aux_q   <= '0;
      cks_q   <= '0;
      data_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fld_q   <= fld_d;
      dig_q   <= dig_d;
      ch_q    <= ch_d;
      aux_q   <= aux_d;
      cks_q   <= cks_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (i_tx_start) state_d = S_WAIT_RDY;
      S_WAIT_RDY: if (i_tx_empty) state_d = S_STROBE;
      S_STROBE:   state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (!i_tx_empty) state_d = (idx_q == LAST_IDX) ? S_IDLE : S_WAIT_RDY;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_en = (state_q == S_STROBE);
    o_busy  = (state_q != S_IDLE);
  end

  // fld_q walks channels, then aux (== NUM_CH), then trailer; dig_q is the position within it
  always_comb begin
    ch_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (fld_q == FLD_W'(c)) ch_sel = ch_q[c*CH_WIDTH +: CH_WIDTH];
    end
    ch_pad                  = '0;
    ch_pad[CH_WIDTH-1:0]    = ch_sel;
    aux_pad                 = '0;
    aux_pad[AUX_WIDTH-1:0]  = aux_q;
    ch_nib = '0;
    for (int d = 0; d < DCH; d++) begin
      if (dig_q == DIG_W'(d)) ch_nib = ch_pad[(DCH-1-d)*4 +: 4];
    end
    aux_nib = '0;
    for (int d = 0; d < DAUX; d++) begin
      if (dig_q == DIG_W'(d)) aux_nib = aux_pad[(DAUX-1-d)*4 +: 4];
    end
    if (fld_q < FLD_W'(NUM_CH)) begin
      cur_byte = (dig_q == DIG_W'(DCH)) ? SEP : hex_char(ch_nib);
    end else if (fld_q == FLD_W'(NUM_CH)) begin
      cur_byte = hex_char(aux_nib);
    end else if (CKSUM_EN != 0) begin
      case (dig_q)
        5'd0:    cur_byte = 8'h2A;
        5'd1:    cur_byte = hex_char(cks_q[7:4]);
        5'd2:    cur_byte = hex_char(cks_q[3:0]);
        5'd3:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
    end else begin
      cur_byte = (dig_q == 5'd0) ? 8'h0D : 8'h0A;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    fld_d  = fld_q;
    dig_d  = dig_q;
    ch_d   = ch_q;
    aux_d  = aux_q;
    cks_d  = cks_q;
    data_d = data_q;
    ovr_d  = ovr_q;
    if (i_tx_start && (state_q != S_IDLE) && (ovr_q != {OVR_WIDTH{1'b1}})) begin
      ovr_d = ovr_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (i_tx_start) begin
          ch_d  = i_ch_data;
          aux_d = i_aux_data;
          cks_d = '0;
          idx_d = '0;
          fld_d = '0;
          dig_d = '0;
        end
      end
      S_WAIT_RDY: if (i_tx_empty) data_d = cur_byte;
      S_STROBE:   if (fld_q <= FLD_W'(NUM_CH)) cks_d = cks_q ^ data_q;
      S_WAIT_ACK: begin
        if (!i_tx_empty && (idx_q != LAST_IDX)) begin
          idx_d = idx_q + 1'b1;
          if ((fld_q < FLD_W'(NUM_CH) && dig_q == DIG_W'(DCH)) ||
              (fld_q == FLD_W'(NUM_CH) && dig_q == DIG_W'(DAUX - 1))) begin
            fld_d = fld_q + 1'b1;
            dig_d = '0;
          end else begin
            dig_d = dig_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_tx_data     = data_q;
  assign o_overrun_cnt = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_record_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hex_record_tx : directed + randomized bench for hex_record_tx with a  |
// |                    byte-level record model and a simple uart_tx model.   |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_hex_record_tx;
  localparam int NCH = 5, CHW = 30, AUXW = 28, LEN = 54;
  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [NCH*CHW-1:0] ch_a = '0;
  logic [AUXW-1:0]    aux_a = '0;
  logic               start_a = 1'b0, empty_a = 1'b1;
  logic [7:0]         data_a, ovr_a;
  logic               en_a, busy_a;

  logic [7:0] ch_b = '0;
  logic [3:0] aux_b = '0;
  logic       start_b = 1'b0, empty_b = 1'b1;
  logic [7:0] data_b, ovr_b;
  logic       en_b, busy_b;

  int n_pass = 0, n_total = 0;
  int hold_a = 0, low_a = 10, cnt_a = 0, cnt_b = 0;
  bit stuck_a = 1'b0;
  bq_t got_a, got_b;
  logic [63:0] va [16];
  logic [63:0] vaux;

  hex_record_tx dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_data(ch_a), .i_aux_data(aux_a),
    .i_tx_start(start_a), .i_tx_empty(empty_a), .o_tx_data(data_a),
    .o_tx_en(en_a), .o_busy(busy_a), .o_overrun_cnt(ovr_a)
  );

  hex_record_tx #(.NUM_CH(1), .CH_WIDTH(8), .AUX_WIDTH(4), .SEP(8'h2C), .CKSUM_EN(1), .OVR_WIDTH(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_data(ch_b), .i_aux_data(aux_b),
    .i_tx_start(start_b), .i_tx_empty(empty_b), .o_tx_data(data_b),
    .o_tx_en(en_b), .o_busy(busy_b), .o_overrun_cnt(ovr_b)
  );

  // uart_tx stand-in: after a strobe, empty stays high hold_a cycles, then low low_a cycles
  always @(negedge clk) begin
    if (en_a) begin
      got_a.push_back(data_a);
      cnt_a = hold_a + low_a;
    end else if (cnt_a > 0) begin
      cnt_a--;
    end
    empty_a = !stuck_a && !(cnt_a > 0 && cnt_a <= low_a);
  end

  always @(negedge clk) begin
    if (en_b) begin
      got_b.push_back(data_b);
      cnt_b = 4;
    end else if (cnt_b > 0) begin
      cnt_b--;
    end
    empty_b = (cnt_b == 0);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic bq_t model(input int nch, input int chw, input int auxw, input int ck,
                                input logic [63:0] cv [16], input logic [63:0] av);
    bq_t q;
    string hx = "0123456789ABCDEF";
    logic [7:0] x = 8'h00;
    for (int c = 0; c < nch; c++) begin
      for (int d = (chw + 3) / 4 - 1; d >= 0; d--) q.push_back(hx[int'((cv[c] >> (4 * d)) & 64'hF)]);
      q.push_back(8'h2C);
    end
    for (int d = (auxw + 3) / 4 - 1; d >= 0; d--) q.push_back(hx[int'((av >> (4 * d)) & 64'hF)]);
    if (ck != 0) begin
      foreach (q[i]) x ^= q[i];
      q.push_back(8'h2A);
      q.push_back(hx[int'(x[7:4])]);
      q.push_back(hx[int'(x[3:0])]);
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  function automatic bq_t str_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic cmp(input string tag, input bq_t got, input bq_t exp);
    int bad = 0, first = -1;
    check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i >= got.size() || got[i] !== exp[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0) $display("  %s: first differing byte index %0d", tag, first);
    check({tag, "_bad_bytes"}, 64'(bad), 64'd0);
  endtask

  task automatic rand_a;
    for (int c = 0; c < NCH; c++) va[c] = {$urandom, $urandom} & ((64'd1 << CHW) - 1);
    vaux = {$urandom, $urandom} & ((64'd1 << AUXW) - 1);
  endtask

  task automatic start_rec_a;
    for (int c = 0; c < NCH; c++) ch_a[c*CHW +: CHW] = va[c][CHW-1:0];
    aux_a   = vaux[AUXW-1:0];
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int bound, input bit scr, input string tag);
    int n = 0;
    while (busy_a === 1'b1 && n < bound) begin
      if (scr) begin
        for (int c = 0; c < NCH; c++) ch_a[c*CHW +: CHW] = CHW'($urandom);
        aux_a = AUXW'($urandom);
      end
      tick;
      n++;
    end
    check(tag, 64'(busy_a), 64'd0);
  endtask

  initial begin
    bq_t exp;
    int n;
    tick;
    tick;
    check("rst_tx_en", 64'(en_a), 64'd0);
    check("rst_tx_data", 64'(data_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_ovr", 64'(ovr_a), 64'd0);
    rst_n = 1'b1;
    tick;

    // record 1: fixed values, latency and exact text
    va[0] = 64'h12345678; va[1] = 64'h3FFFFFFF; va[2] = 64'h0;
    va[3] = 64'h00ABCDEF; va[4] = 64'h20000001; vaux = 64'h2FAF080;
    got_a.delete();
    start_rec_a;
    check("busy_after_start", 64'(busy_a), 64'd1);
    check("lat_cycle1_no_en", 64'(en_a), 64'd0);
    tick;
    check("lat_cycle2_en", 64'(en_a), 64'd1);
    wait_idle_a(LEN * 14 + 20, 1'b0, "r1_done");
    cmp("r1", got_a, str_q("12345678,3FFFFFFF,00000000,00ABCDEF,20000001,2FAF080"));

    // record 2: random snapshot, inputs scrambled every cycle during the record
    rand_a;
    got_a.delete();
    start_rec_a;
    wait_idle_a(LEN * 14 + 20, 1'b1, "r2_done");
    cmp("r2", got_a, model(NCH, CHW, AUXW, 0, va, vaux));

    // record 3: start in the first idle cycle; empty lingers high 3 cycles after each strobe
    hold_a = 3; low_a = 6;
    rand_a;
    got_a.delete();
    start_rec_a;
    check("first_idle_accept", 64'(busy_a), 64'd1);
    check("first_idle_no_ovr", 64'(ovr_a), 64'd0);
    wait_idle_a(LEN * 14 + 20, 1'b0, "r3_done");
    cmp("r3", got_a, model(NCH, CHW, AUXW, 0, va, vaux));

    // record 4: overruns, then saturation
    hold_a = 0; low_a = 10;
    rand_a;
    got_a.delete();
    start_rec_a;
    repeat (4) tick;
    repeat (3) begin
      start_a = 1'b1; tick;
      start_a = 1'b0; tick;
    end
    check("ovr_three", 64'(ovr_a), 64'd3);
    start_a = 1'b1;
    repeat (300) tick;
    start_a = 1'b0;
    check("ovr_saturated", 64'(ovr_a), 64'd255);
    check("ovr_still_busy", 64'(busy_a), 64'd1);
    wait_idle_a(LEN * 14 + 20, 1'b0, "r4_done");
    cmp("r4", got_a, model(NCH, CHW, AUXW, 0, va, vaux));

    // record 5: asynchronous reset at byte 20
    rand_a;
    got_a.delete();
    start_rec_a;
    n = 0;
    while (got_a.size() < 20 && n < 20 * 14) begin tick; n++; end
    check("r5_reached_byte20", 64'(got_a.size()), 64'd20);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy_a), 64'd0);
    check("async_rst_en", 64'(en_a), 64'd0);
    check("async_rst_data", 64'(data_a), 64'd0);
    check("async_rst_ovr", 64'(ovr_a), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // record 6: fresh record after reset; start during final ack counts as overrun
    repeat (12) tick;
    rand_a;
    got_a.delete();
    start_rec_a;
    n = 0;
    while (!(got_a.size() == LEN && en_a == 1'b0 && busy_a == 1'b1) && n < LEN * 14 + 20) begin tick; n++; end
    check("r6_last_ack", 64'(got_a.size()), 64'(LEN));
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    check("final_ack_busy_fell", 64'(busy_a), 64'd0);
    check("final_ack_ovr", 64'(ovr_a), 64'd1);
    tick;
    check("final_ack_not_accepted", 64'(busy_a), 64'd0);
    cmp("r6", got_a, model(NCH, CHW, AUXW, 0, va, vaux));

    // empty stuck low: stall with no strobes, then reset recovers
    stuck_a = 1'b1;
    repeat (12) tick;
    rand_a;
    got_a.delete();
    start_rec_a;
    repeat (40) tick;
    check("stuck_busy", 64'(busy_a), 64'd1);
    check("stuck_no_bytes", 64'(got_a.size()), 64'd0);
    rst_n = 1'b0;
    tick;
    check("stuck_reset_idle", 64'(busy_a), 64'd0);
    stuck_a = 1'b0;
    rst_n = 1'b1;
    tick;

    // small configuration with checksum
    got_b.delete();
    ch_b = 8'hA5; aux_b = 4'h3;
    start_b = 1'b1; tick; start_b = 0;
    n = 0;
    while (busy_b === 1'b1 && n < 200) begin tick; n++; end
    check("b1_done", 64'(busy_b), 64'd0);
    cmp("b1", got_b, str_q("A5,3*6B"));
    for (int k = 0; k < 3; k++) begin
      va[0] = 64'($urandom_range(0, 255));
      vaux  = 64'($urandom_range(0, 15));
      got_b.delete();
      ch_b = va[0][7:0]; aux_b = vaux[3:0];
      start_b = 1'b1; tick; start_b = 0;
      n = 0;
      while (busy_b === 1'b1 && n < 200) begin tick; n++; end
      check("bk_done", 64'(busy_b), 64'd0);
      cmp("bk", got_b, model(1, 8, 4, 1, va, vaux));
      tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
